// File: rtl/ccsds_ldpc_pkg.sv
// Shared definitions for the CCSDS LDPC systematic-bit extractor.
// Code table lookup (N, K) keyed by the code string, statistics width and
// an elaboration-time sanity check of the code/bus-width combination.
package ccsds_ldpc_pkg;

    localparam int unsigned STAT_W = 16;
    // Longest code string is "32768,16384" (11 characters).
    localparam int unsigned STR_W  = 88;

    function automatic int unsigned ldpc_n(input logic [STR_W-1:0] s);
        case (s)
            STR_W'("8176,7154"):   return 8176;
            STR_W'("8160,7136"):   return 8160;
            STR_W'("1280,1024"):   return 1280;
            STR_W'("1536,1024"):   return 1536;
            STR_W'("2048,1024"):   return 2048;
            STR_W'("5120,4096"):   return 5120;
            STR_W'("6144,4096"):   return 6144;
            STR_W'("8192,4096"):   return 8192;
            STR_W'("20480,16384"): return 20480;
            STR_W'("24576,16384"): return 24576;
            STR_W'("32768,16384"): return 32768;
            default:               return 0;
        endcase
    endfunction

    function automatic int unsigned ldpc_k(input logic [STR_W-1:0] s);
        case (s)
            STR_W'("8176,7154"):   return 7154;
            STR_W'("8160,7136"):   return 7136;
            STR_W'("1280,1024"):   return 1024;
            STR_W'("1536,1024"):   return 1024;
            STR_W'("2048,1024"):   return 1024;
            STR_W'("5120,4096"):   return 4096;
            STR_W'("6144,4096"):   return 4096;
            STR_W'("8192,4096"):   return 4096;
            STR_W'("20480,16384"): return 16384;
            STR_W'("24576,16384"): return 16384;
            STR_W'("32768,16384"): return 16384;
            default:               return 0;
        endcase
    endfunction

    // True when the code is known and both N and K split into whole beats.
    function automatic bit ldpc_cfg_ok(input logic [STR_W-1:0] s, input int unsigned w);
        int unsigned n;
        int unsigned k;
        n = ldpc_n(s);
        k = ldpc_k(s);
        return (w != 0) && (n != 0) && (k != 0) && (k < n) && (n % w == 0) && (k % w == 0);
    endfunction

endpackage

// File: rtl/ccsds_ldpc_axis_reg.sv
// Single-stage AXI-Stream register (data + last) with full throughput:
// a new beat may be loaded in the same cycle the held beat drains.
module ccsds_ldpc_axis_reg #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] in_data_i,
    input  logic             in_last_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [width-1:0] out_data_o,
    output logic             out_last_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [width-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic             fire;

    // Next-state: load on input handshake, otherwise clear valid once drained.
    always_comb begin
        in_ready_o = !valid_q || out_ready_i;
        fire       = in_valid_i && in_ready_o;
        data_d     = data_q;
        last_d     = last_q;
        valid_d    = valid_q;
        if (fire) begin
            data_d  = in_data_i;
            last_d  = in_last_i;
            valid_d = 1'b1;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/ccsds_ldpc_sys_extractor.sv
// CCSDS LDPC systematic-bit extractor (hard-decision / bypass receive path).
// Forwards the first KB beats of each NB-beat codeword, drops the parity beats,
// and checks framing against tlast, resynchronising on any framing error.
// Optional block statistics counters: define CCSDS_LDPC_EXTRACT_STATS_EN.
module ccsds_ldpc_sys_extractor
    import ccsds_ldpc_pkg::*;
#(
    parameter logic [STR_W-1:0] stander = STR_W'("1280,1024"),
    parameter int unsigned      width   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [width-1:0]  s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [width-1:0]  m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              err_early,
    output logic              err_late,
    output logic [STAT_W-1:0] blk_ok_cnt,
    output logic [STAT_W-1:0] blk_err_cnt
);

    localparam int unsigned N   = ldpc_n(stander);
    localparam int unsigned K   = ldpc_k(stander);
    localparam int unsigned NB  = N / width;
    localparam int unsigned KB  = K / width;
    localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;

    if (!ldpc_cfg_ok(stander, width)) begin : g_bad_cfg
        $fatal(1, "ccsds_ldpc_sys_extractor: unknown code or N/K not a multiple of width");
    end

    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
    logic           err_early_q, err_early_d;
    logic           err_late_q, err_late_d;
    logic           in_info;
    logic           last_beat;
    logic           accept;
    logic           load;
    logic           load_last;
    logic           reg_in_ready;

    // Beat position, handshake steering and framing checks.
    always_comb begin
        in_info       = beat_cnt_q < BCW'(KB);
        last_beat     = beat_cnt_q == BCW'(NB - 1);
        // Parity beats are dropped, so they never wait on the output register.
        s_axis_tready = in_info ? reg_in_ready : 1'b1;
        accept        = s_axis_tvalid && s_axis_tready;
        load          = accept && in_info;
        // Early tlast inside the info phase closes a truncated block.
        load_last     = s_axis_tlast || (beat_cnt_q == BCW'(KB - 1));
        err_early_d   = accept && s_axis_tlast && !last_beat;
        err_late_d    = accept && !s_axis_tlast && last_beat;
        beat_cnt_d    = beat_cnt_q;
        if (accept) begin
            beat_cnt_d = (s_axis_tlast || last_beat) ? '0 : beat_cnt_q + BCW'(1);
        end
    end

    // Beat counter and registered error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
        end
    end

    assign err_early = err_early_q;
    assign err_late  = err_late_q;

    ccsds_ldpc_axis_reg #(
        .width (width)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (s_axis_tdata),
        .in_last_i   (load_last),
        .in_valid_i  (load),
        .in_ready_o  (reg_in_ready),
        .out_data_o  (m_axis_tdata),
        .out_last_o  (m_axis_tlast),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready)
    );

`ifdef CCSDS_LDPC_EXTRACT_STATS_EN
    logic [STAT_W-1:0] blk_ok_cnt_q, blk_ok_cnt_d;
    logic [STAT_W-1:0] blk_err_cnt_q, blk_err_cnt_d;
    logic              blk_good;

    // Saturating good-block and framing-error counters.
    always_comb begin
        blk_good      = accept && s_axis_tlast && last_beat;
        blk_ok_cnt_d  = blk_ok_cnt_q;
        blk_err_cnt_d = blk_err_cnt_q;
        if (blk_good && (blk_ok_cnt_q != '1)) begin
            blk_ok_cnt_d = blk_ok_cnt_q + STAT_W'(1);
        end
        if ((err_early_d || err_late_d) && (blk_err_cnt_q != '1)) begin
            blk_err_cnt_d = blk_err_cnt_q + STAT_W'(1);
        end
    end

    // Statistics state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_ok_cnt_q  <= '0;
            blk_err_cnt_q <= '0;
        end else begin
            blk_ok_cnt_q  <= blk_ok_cnt_d;
            blk_err_cnt_q <= blk_err_cnt_d;
        end
    end

    assign blk_ok_cnt  = blk_ok_cnt_q;
    assign blk_err_cnt = blk_err_cnt_q;
`else
    assign blk_ok_cnt  = '0;
    assign blk_err_cnt = '0;
`endif

endmodule

// File: tb/tb_ccsds_ldpc_sys_extractor.sv
// Self-checking bench for ccsds_ldpc_sys_extractor ("1280,1024", width 8).
// A queue-based model of the codeword rules predicts every output beat and
// the framing/statistics results; random data and random downstream ready.
`timescale 1ns/1ps

`define CHECK(TAG, OBS, EXP) \
    begin \
        checks++; \
        assert ((OBS) === (EXP)) else begin \
            errors++; \
            $error("FAIL %s: observed %0h, expected %0h", TAG, (OBS), (EXP)); \
        end \
    end

module tb_ccsds_ldpc_sys_extractor;

    localparam int NB = 160;
    localparam int KB = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        err_early;
    logic        err_late;
    logic [15:0] blk_ok_cnt;
    logic [15:0] blk_err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [8:0] exp_q[$];  // {last, data} of each expected output beat
    int pos = 0;           // position of the next input beat in its codeword
    int mod_ok = 0;
    int mod_err = 0;

    // Monitor state.
    int   mon_beats = 0;
    int   mon_early = 0;
    int   mon_late = 0;
    int   in_stalls = 0;
    bit   rand_ready = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;

    ccsds_ldpc_sys_extractor dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .err_early     (err_early),
        .err_late      (err_late),
        .blk_ok_cnt    (blk_ok_cnt),
        .blk_err_cnt   (blk_err_cnt)
    );

    always #5 clk = ~clk;

    // Downstream ready: 30 % low when randomised.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                `CHECK("rst_m_tvalid", m_axis_tvalid, 1'b0)
                `CHECK("rst_m_tlast", m_axis_tlast, 1'b0)
                `CHECK("rst_m_tdata", m_axis_tdata, 8'h00)
                `CHECK("rst_err_early", err_early, 1'b0)
                `CHECK("rst_err_late", err_late, 1'b0)
                `CHECK("rst_blk_ok_cnt", blk_ok_cnt, 16'h0000)
                `CHECK("rst_blk_err_cnt", blk_err_cnt, 16'h0000)
            end else begin
                if (prev_stall) begin
                    `CHECK("hold_valid", m_axis_tvalid, 1'b1)
                    `CHECK("hold_data", m_axis_tdata, prev_data)
                    `CHECK("hold_last", m_axis_tlast, prev_last)
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    `CHECK("out_expected", exp_q.size() != 0, 1'b1)
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        `CHECK("out_data", m_axis_tdata, e[7:0])
                        `CHECK("out_last", m_axis_tlast, e[8])
                    end
                    mon_beats++;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
                if (err_early) mon_early++;
                if (err_late) mon_late++;
                if (pos >= KB) begin
                    `CHECK("parity_tready", s_axis_tready, 1'b1)
                end
            end
        end
    end

    // Model of one accepted input beat.
    task automatic model_accept(input logic [7:0] d, input logic l);
        if (pos < KB) exp_q.push_back({(l || pos == KB - 1), d});
        if (l && pos == NB - 1) mod_ok++;
        else if (l || pos == NB - 1) mod_err++;
        pos = (l || pos == NB - 1) ? 0 : pos + 1;
    endtask

    // Present one beat until accepted (called at posedge + 1).
    task automatic send_beat(input logic [7:0] d, input logic l);
        logic acc;
        int   n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            if (acc) break;
            in_stalls++;
            n++;
            if (n >= 1000) begin
                `CHECK("beat_accept_timeout", acc, 1'b1)
                $fatal(1, "input beat never accepted");
            end
        end
        model_accept(d, l);
    endtask

    // nbeats random beats, tlast on beat last_at (-1: never).
    task automatic send_cw(input int nbeats, input int last_at);
        for (int i = 0; i < nbeats; i++) begin
            send_beat(8'($urandom), (i == last_at));
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int    n = 0;
        string t;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        t = {tag, "_drained"};
        `CHECK(t, exp_q.size(), 0)
    endtask

    task automatic end_test(input string tag, input int beats, input int early, input int late);
        string t;
        logic [15:0] ok_e;
        logic [15:0] err_e;
`ifdef CCSDS_LDPC_EXTRACT_STATS_EN
        ok_e  = 16'(mod_ok);
        err_e = 16'(mod_err);
`else
        ok_e  = 16'h0000;
        err_e = 16'h0000;
`endif
        drain(tag);
        t = {tag, "_beats"};
        `CHECK(t, mon_beats, beats)
        t = {tag, "_err_early"};
        `CHECK(t, mon_early, early)
        t = {tag, "_err_late"};
        `CHECK(t, mon_late, late)
        t = {tag, "_blk_ok_cnt"};
        `CHECK(t, blk_ok_cnt, ok_e)
        t = {tag, "_blk_err_cnt"};
        `CHECK(t, blk_err_cnt, err_e)
        mon_beats = 0;
        mon_early = 0;
        mon_late  = 0;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        `CHECK("reset_m_tvalid", m_axis_tvalid, 1'b0)
        `CHECK("reset_blk_ok_cnt", blk_ok_cnt, 16'h0000)
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: three back-to-back codewords, ready always high, no bubbles.
        in_stalls = 0;
        for (int c = 0; c < 3; c++) send_cw(NB, NB - 1);
        `CHECK("t1_input_stalls", in_stalls, 0)
        end_test("t1", 384, 0, 0);

        // T2: random downstream ready.
        rand_ready = 1'b1;
        for (int c = 0; c < 4; c++) send_cw(NB, NB - 1);
        end_test("t2", 512, 0, 0);
        rand_ready = 1'b0;

        // T3: tlast on info beat 99, then a full codeword.
        send_cw(100, 99);
        send_cw(NB, NB - 1);
        end_test("t3", 228, 1, 0);

        // T4: tlast on parity beat 140, then a full codeword.
        send_cw(141, 140);
        send_cw(NB, NB - 1);
        end_test("t4", 256, 1, 0);

        // T5: 160 beats without tlast, then a full codeword.
        send_cw(NB, -1);
        send_cw(NB, NB - 1);
        end_test("t5", 256, 0, 1);

        // T6: reset asserted while info beat 50 is on the bus.
        send_cw(50, -1);
        s_axis_tdata  = 8'($urandom);
        s_axis_tvalid = 1'b1;
        rst           = 1'b1;
        exp_q.delete();
        pos     = 0;
        mod_ok  = 0;
        mod_err = 0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        mon_beats = 0;
        mon_early = 0;
        mon_late  = 0;
        send_cw(NB, NB - 1);
        end_test("t6", 128, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
